// File: rtl/riscv_pu_instr_fetch.sv
// Instruction fetch unit: one-outstanding AXI-style read channel, a one-entry
// skid buffer for decode back-pressure, and redirect handling with response discard.
module riscv_pu_instr_fetch #(
    parameter int                    DATA_WIDTH  = 64,
    parameter int                    INSTR_WIDTH = 32,
    parameter logic [DATA_WIDTH-1:0] RESET_PC    = '0
) (
    input  logic                   clk,
    input  logic                   nreset,
    input  logic                   enable,
    input  logic                   i_stall,
    input  logic                   i_pc_src,
    input  logic [DATA_WIDTH-1:0]  i_pc_target,
    output logic                   o_imem_arvalid,
    input  logic                   i_imem_arready,
    output logic [DATA_WIDTH-1:0]  o_imem_araddr,
    input  logic                   i_imem_rvalid,
    output logic                   o_imem_rready,
    input  logic [INSTR_WIDTH-1:0] i_imem_rdata,
    output logic [INSTR_WIDTH-1:0] o_instr,
    output logic [DATA_WIDTH-1:0]  o_pc,
    output logic                   o_valid
);

    localparam logic [INSTR_WIDTH-1:0] NOP = INSTR_WIDTH'(32'h0000_0013);

    typedef enum logic [1:0] {IDLE, ADDR, DATA, BUF} state_t;

    state_t                 state_q, state_d;
    logic [DATA_WIDTH-1:0]  pc_q, req_addr_q, rpc_q, buf_pc_q, target;
    logic [INSTR_WIDTH-1:0] buf_instr_q;
    logic                   discard_q, discard_d;
    logic                   req_from_pc, req_from_tgt, ar_hs;
    logic                   ld_rdata, ld_buf, cap_buf;

    assign target        = i_pc_target & ~DATA_WIDTH'(3);
    assign o_imem_araddr = req_addr_q;

    always_comb begin
        state_d        = state_q;
        discard_d      = discard_q;
        req_from_pc    = 1'b0;
        req_from_tgt   = 1'b0;
        ar_hs          = 1'b0;
        ld_rdata       = 1'b0;
        ld_buf         = 1'b0;
        cap_buf        = 1'b0;
        o_imem_arvalid = 1'b0;
        o_imem_rready  = 1'b0;
        case (state_q)
            IDLE: begin
                if (enable) begin
                    state_d = ADDR;
                    if (i_pc_src) req_from_tgt = 1'b1;
                    else          req_from_pc  = 1'b1;
                end
            end
            ADDR: begin
                // The address phase is never withdrawn; a redirect only marks the reply as stale.
                o_imem_arvalid = 1'b1;
                if (i_pc_src) discard_d = 1'b1;
                if (i_imem_arready) begin
                    ar_hs   = 1'b1;
                    state_d = DATA;
                end
            end
            DATA: begin
                o_imem_rready = 1'b1;
                if (i_imem_rvalid) begin
                    if (discard_q) begin
                        discard_d = 1'b0;
                        state_d   = IDLE;
                    end else if (i_pc_src) begin
                        req_from_tgt = 1'b1;
                        state_d      = ADDR;
                    end else if (!i_stall) begin
                        ld_rdata = 1'b1;
                        if (enable) begin
                            req_from_pc = 1'b1;
                            state_d     = ADDR;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        cap_buf = 1'b1;
                        state_d = BUF;
                    end
                end else if (i_pc_src) begin
                    discard_d = 1'b1;
                end
            end
            BUF: begin
                if (i_pc_src) begin
                    req_from_tgt = 1'b1;
                    state_d      = ADDR;
                end else if (!i_stall) begin
                    ld_buf = 1'b1;
                    if (enable) begin
                        req_from_pc = 1'b1;
                        state_d     = ADDR;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state_q   <= IDLE;
            discard_q <= 1'b0;
            pc_q      <= RESET_PC;
            o_valid   <= 1'b0;
            o_instr   <= NOP;
            o_pc      <= '0;
        end else begin
            state_q   <= state_d;
            discard_q <= discard_d;
            // A handshake of an already-redirected request must not overwrite the target.
            if (i_pc_src)
                pc_q <= target;
            else if (ar_hs && !discard_q)
                pc_q <= req_addr_q + DATA_WIDTH'(4);
            if (i_pc_src) begin
                o_valid <= 1'b0;
                o_instr <= NOP;
            end else if (!i_stall) begin
                if (ld_rdata) begin
                    o_valid <= 1'b1;
                    o_instr <= i_imem_rdata;
                    o_pc    <= rpc_q;
                end else if (ld_buf) begin
                    o_valid <= 1'b1;
                    o_instr <= buf_instr_q;
                    o_pc    <= buf_pc_q;
                end else begin
                    o_valid <= 1'b0;
                    o_instr <= NOP;
                end
            end
        end
    end

    // Address and buffer payload are qualified by the FSM state, so they carry no reset.
    always_ff @(posedge clk) begin
        if (req_from_tgt)
            req_addr_q <= target;
        else if (req_from_pc)
            req_addr_q <= pc_q;
        if (ar_hs)
            rpc_q <= req_addr_q;
        if (cap_buf) begin
            buf_instr_q <= i_imem_rdata;
            buf_pc_q    <= rpc_q;
        end
    end

endmodule

// File: tb/tb_riscv_pu_instr_fetch.sv
// Bench for riscv_pu_instr_fetch: configurable-latency memory model, a scoreboard
// of expected (pc, instr) pairs, a fetch-address table and hand-written corner cases.
module tb_riscv_pu_instr_fetch;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        nreset, enable, i_stall, i_pc_src;
    logic [63:0] i_pc_target;
    logic        o_imem_arvalid, i_imem_arready, i_imem_rvalid, o_imem_rready;
    logic [63:0] o_imem_araddr, o_pc;
    logic [31:0] i_imem_rdata, o_instr;
    logic        o_valid;

    riscv_pu_instr_fetch #(.DATA_WIDTH(64), .INSTR_WIDTH(32), .RESET_PC(64'h100)) dut (
        .clk(clk), .nreset(nreset), .enable(enable), .i_stall(i_stall),
        .i_pc_src(i_pc_src), .i_pc_target(i_pc_target),
        .o_imem_arvalid(o_imem_arvalid), .i_imem_arready(i_imem_arready),
        .o_imem_araddr(o_imem_araddr), .i_imem_rvalid(i_imem_rvalid),
        .o_imem_rready(o_imem_rready), .i_imem_rdata(i_imem_rdata),
        .o_instr(o_instr), .o_pc(o_pc), .o_valid(o_valid)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] pc;
        logic [31:0] instr;
    } exp_t;

    typedef struct {
        bit          redir;
        logic [63:0] tgt;
        int          lat;
        int          wt;
        logic [63:0] e0, e1, e2;
    } vec_t;

    exp_t        sb_q[$];
    logic [63:0] ar_log[$];
    vec_t        vecs[4];

    int          n_tests = 0, n_fail = 0;
    int          latency = 0, ar_wait = 0, lat_cnt = 0, wait_cnt = 0, r_cnt = 0;
    int          multi_err = 0, stable_err = 0, nop_err = 0;
    bit          pending = 0, drop_next = 0, prev_ar_stall = 0;
    bit          stall_at_edge = 0, pcsrc_at_edge = 0;
    logic [63:0] rd_addr = '0, prev_araddr = '0, special_addr = '1;
    logic [31:0] special_word = '0;

    function automatic logic [31:0] mem_word(input logic [63:0] a);
        if (a == special_addr) return special_word;
        return a[31:0] ^ 32'hC0DE_0000;
    endfunction

    function automatic logic [63:0] log_at(input int k);
        if (ar_log.size() > k) return ar_log[k];
        return 64'hBAD0_BAD0_BAD0_BAD0;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Memory bookkeeping and protocol observation at the active edge.
    always @(posedge clk) begin
        stall_at_edge = i_stall;
        pcsrc_at_edge = i_pc_src;
        if (!nreset) begin
            pending       = 0;
            lat_cnt       = 0;
            wait_cnt      = 0;
            prev_ar_stall = 0;
        end else begin
            if (o_imem_arvalid && pending) multi_err++;
            if (prev_ar_stall && (!o_imem_arvalid || o_imem_araddr != prev_araddr)) stable_err++;
            prev_ar_stall = o_imem_arvalid && !i_imem_arready;
            prev_araddr   = o_imem_araddr;
            if (i_imem_rvalid && o_imem_rready) begin
                pending = 0;
                r_cnt++;
            end
            if (o_imem_arvalid && i_imem_arready) begin
                ar_log.push_back(o_imem_araddr);
                pending  = 1;
                rd_addr  = o_imem_araddr;
                lat_cnt  = 0;
                wait_cnt = 0;
                if (drop_next) drop_next = 0;
                else sb_q.push_back('{pc: o_imem_araddr, instr: mem_word(o_imem_araddr)});
            end
        end
    end

    // Memory drives its response channel on the falling edge.
    always @(negedge clk) begin
        if (!nreset) begin
            i_imem_arready = 1'b0;
            i_imem_rvalid  = 1'b0;
        end else begin
            i_imem_arready = o_imem_arvalid && !pending && (wait_cnt >= ar_wait);
            if (o_imem_arvalid && !pending && !i_imem_arready) wait_cnt++;
            i_imem_rvalid = pending && (lat_cnt >= latency);
            i_imem_rdata  = i_imem_rvalid ? mem_word(rd_addr) : 32'hDEAD_BEEF;
            if (pending) lat_cnt++;
        end
    end

    // Output monitor: every cycle updated without stall or redirect that shows valid is a new instruction.
    always @(negedge clk) begin
        if (nreset) begin
            if (!o_valid && o_instr !== NOP) nop_err++;
            if (o_valid && !stall_at_edge && !pcsrc_at_edge) begin
                if (sb_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL sb_unexpected: got pc 0x%0h instr 0x%0h, expected no instruction", o_pc, o_instr);
                end else begin
                    exp_t e;
                    e = sb_q.pop_front();
                    check("sb_pc", o_pc, e.pc);
                    check("sb_instr", {32'h0, o_instr}, {32'h0, e.instr});
                end
            end
        end
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic redirect_idle(input logic [63:0] t);
        i_pc_target = t;
        i_pc_src    = 1'b1;
        step();
        i_pc_src    = 1'b0;
    endtask

    task automatic wait_log(input int n, input string name);
        for (int i = 0; i < 400 && ar_log.size() < n; i++) step();
        check(name, 64'(ar_log.size() >= n), 64'd1);
    endtask

    task automatic wait_valid(input string name);
        for (int i = 0; i < 400 && !o_valid; i++) step();
        check(name, 64'(o_valid), 64'd1);
    endtask

    task automatic quiesce(input string name);
        int idle;
        idle = 0;
        for (int i = 0; i < 400 && idle < 3; i++) begin
            step();
            if (!o_imem_arvalid && !o_imem_rready && !pending) idle++;
            else idle = 0;
        end
        check(name, 64'(idle), 64'd3);
    endtask

    initial begin
        vecs[0] = '{redir: 0, tgt: 64'h0, lat: 0, wt: 0,
                    e0: 64'h100, e1: 64'h104, e2: 64'h108};
        vecs[1] = '{redir: 1, tgt: 64'h1001, lat: 2, wt: 1,
                    e0: 64'h1000, e1: 64'h1004, e2: 64'h1008};
        vecs[2] = '{redir: 1, tgt: 64'hFFFF_FFFF_FFFF_FFFE, lat: 0, wt: 0,
                    e0: 64'hFFFF_FFFF_FFFF_FFFC, e1: 64'h0, e2: 64'h4};
        vecs[3] = '{redir: 1, tgt: 64'h8000_0000_0000_0003, lat: 1, wt: 2,
                    e0: 64'h8000_0000_0000_0000, e1: 64'h8000_0000_0000_0004, e2: 64'h8000_0000_0000_0008};

        nreset = 1'b0; enable = 1'b0; i_stall = 1'b0; i_pc_src = 1'b0; i_pc_target = '0;
        i_imem_arready = 1'b0; i_imem_rvalid = 1'b0; i_imem_rdata = '0;
        step(); step();
        check("rst_arvalid", 64'(o_imem_arvalid), 64'd0);
        check("rst_rready", 64'(o_imem_rready), 64'd0);
        check("rst_valid", 64'(o_valid), 64'd0);
        check("rst_instr", {32'h0, o_instr}, {32'h0, NOP});
        check("rst_pc", o_pc, 64'h0);
        nreset = 1'b1;
        step(); step(); step();
        check("no_fetch_without_enable", 64'(o_imem_arvalid), 64'd0);

        for (int v = 0; v < 4; v++) begin
            ar_log.delete();
            latency = vecs[v].lat;
            ar_wait = vecs[v].wt;
            if (vecs[v].redir) redirect_idle(vecs[v].tgt);
            enable = 1'b1;
            wait_log(3, "vec_fetch_timeout");
            enable = 1'b0;
            quiesce("vec_quiesce");
            check($sformatf("vec%0d_addr0", v), log_at(0), vecs[v].e0);
            check($sformatf("vec%0d_addr1", v), log_at(1), vecs[v].e1);
            check($sformatf("vec%0d_addr2", v), log_at(2), vecs[v].e2);
        end

        // Decode stall while a response is pending: the reply parks in the buffer.
        latency = 2; ar_wait = 0;
        special_addr = 64'h304; special_word = 32'h00A0_0093;
        redirect_idle(64'h300);
        enable = 1'b1;
        wait_valid("stall_first_timeout");
        i_stall = 1'b1;
        enable  = 1'b0;
        begin
            int r0;
            r0 = r_cnt;
            for (int i = 0; i < 100 && r_cnt == r0; i++) step();
            check("stall_resp_timeout", 64'(r_cnt > r0), 64'd1);
        end
        step();
        check("buf_rready", 64'(o_imem_rready), 64'd0);
        check("buf_arvalid", 64'(o_imem_arvalid), 64'd0);
        check("buf_hold_valid", 64'(o_valid), 64'd1);
        check("buf_hold_instr", {32'h0, o_instr}, {32'h0, mem_word(64'h300)});
        check("buf_hold_pc", o_pc, 64'h300);
        i_stall = 1'b0;
        step();
        check("buf_release_instr", {32'h0, o_instr}, 64'h00A0_0093);
        check("buf_release_valid", 64'(o_valid), 64'd1);
        check("buf_release_pc", o_pc, 64'h304);
        quiesce("stall_quiesce");

        // Redirect while waiting in DATA for 0x104.
        ar_log.delete();
        latency = 4; ar_wait = 0;
        redirect_idle(64'h100);
        enable = 1'b1;
        wait_log(2, "redir_data_timeout");
        i_pc_target = 64'h203;
        i_pc_src    = 1'b1;
        void'(sb_q.pop_back());
        step();
        i_pc_src = 1'b0;
        check("redir_data_bubble", 64'(o_valid), 64'd0);
        wait_valid("redir_data_valid_timeout");
        check("redir_data_pc", o_pc, 64'h200);
        check("redir_data_addr", log_at(2), 64'h200);
        enable = 1'b0;
        quiesce("redir_data_quiesce");

        // Redirect in ADDR with arready held off: request stays put and its reply is dropped.
        ar_log.delete();
        latency = 0; ar_wait = 3;
        redirect_idle(64'h100);
        enable = 1'b1;
        for (int i = 0; i < 200 && !(o_imem_arvalid && o_imem_araddr == 64'h108); i++) step();
        check("redir_addr_reach", o_imem_araddr, 64'h108);
        i_pc_target = 64'h400;
        i_pc_src    = 1'b1;
        drop_next   = 1;
        step();
        i_pc_src = 1'b0;
        check("redir_addr_hold", o_imem_araddr, 64'h108);
        wait_log(4, "redir_addr_timeout");
        enable = 1'b0;
        quiesce("redir_addr_quiesce");
        check("redir_addr_accepted", log_at(2), 64'h108);
        check("redir_addr_target", log_at(3), 64'h400);

        // Asynchronous reset while a read is outstanding.
        latency = 6; ar_wait = 0;
        enable = 1'b1;
        wait_valid("rst_mid_valid_timeout");
        i_stall = 1'b1;
        for (int i = 0; i < 100 && !pending; i++) step();
        check("rst_mid_in_data", 64'(o_imem_rready), 64'd1);
        #1 nreset = 1'b0;
        #1;
        check("rst_mid_arvalid", 64'(o_imem_arvalid), 64'd0);
        check("rst_mid_rready", 64'(o_imem_rready), 64'd0);
        check("rst_mid_valid", 64'(o_valid), 64'd0);
        check("rst_mid_instr", {32'h0, o_instr}, {32'h0, NOP});
        sb_q.delete();
        i_stall = 1'b0;
        enable  = 1'b0;
        step(); step();
        nreset = 1'b1;
        ar_log.delete();
        latency = 0;
        enable  = 1'b1;
        wait_log(1, "rst_restart_timeout");
        enable = 1'b0;
        quiesce("rst_restart_quiesce");
        check("rst_restart_addr", log_at(0), 64'h100);

        check("sb_drained", 64'(sb_q.size()), 64'd0);
        check("one_outstanding", 64'(multi_err), 64'd0);
        check("araddr_stable", 64'(stable_err), 64'd0);
        check("bubble_is_nop", 64'(nop_err), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation still running at %0t, expected completion earlier", $time);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/riscv_pu_instr_fetch.md
RISCV_PU_INSTR_FETCH -- requirements
Module: riscv_pu_instr_fetch

Interface
REQ-001 The block SHALL have the following parameters:
- DATA_WIDTH, default 64, PC/address width.
- INSTR_WIDTH, default 32, instruction width.
- RESET_PC, default 0, first fetch address.

REQ-002 The block SHALL have the following ports:
- clk  in  1  single clock, rising edge.
- nreset  in  1  reset; asynchronous, active-low.
- enable  in  1  permits new fetch requests.
- i_stall  in  1  decode cannot accept; hold outputs.
- i_pc_src  in  1  redirect strobe (branch/jump taken).
- i_pc_target  in  DATA_WIDTH  redirect address.
- o_imem_arvalid  out  1  read address valid.
- i_imem_arready  in  1  read address accepted.
- o_imem_araddr  out  DATA_WIDTH  fetch address.
- i_imem_rvalid  in  1  read data valid.
- o_imem_rready  out  1  read data accept.
- i_imem_rdata  in  INSTR_WIDTH  fetched word.
- o_instr  out  INSTR_WIDTH  instruction to decode.
- o_pc  out  DATA_WIDTH  PC of o_instr.
- o_valid  out  1  o_instr is a real instruction.

Function
REQ-003 pc_q (next fetch PC) SHALL reset to RESET_PC; i_pc_target[1:0] SHALL be forced to 0 when loaded.

REQ-004 The FSM SHALL have states IDLE, ADDR, DATA and BUF, with reset state IDLE.

REQ-005 IDLE: arvalid=0, rready=0; when enable=1 the FSM SHALL go to ADDR and latch req_addr=pc_q.

REQ-006 ADDR handshake rules:
- arvalid=1, araddr=req_addr.
- araddr SHALL be held stable until arready.
- On arvalid&arready: pc_q<=req_addr+4, rpc<=req_addr, next state DATA.

REQ-007 DATA: rready=1. On rvalid:
- discard=1: drop the data, clear discard, go to IDLE.
- else, i_stall=0: load outputs, then go to ADDR (enable=1) or IDLE.
- else: capture data/rpc into a one-entry buffer, go to BUF.

REQ-008 BUF: rready=0; when i_stall=0 the buffer SHALL be loaded to the outputs and the FSM SHALL go to ADDR if enable=1, else IDLE.

REQ-009 Output loading: o_instr<=word, o_pc<=rpc, o_valid<=1, registered with one cycle of latency from the rvalid handshake or stall release.

REQ-010 When i_stall=0 and nothing is loaded in a cycle, outputs SHALL become a bubble: o_valid<=0, o_instr<=32'h00000013 (NOP), o_pc held.

REQ-011 When i_stall=1, o_instr, o_pc and o_valid SHALL hold.

REQ-012 On i_pc_src=1, pc_q<=i_pc_target and o_valid<=0 (with o_instr NOP) next cycle, regardless of i_stall; redirect has priority over stall and over the +4 increment. Per state:
- IDLE: next fetch uses target.
- ADDR: the request continues unchanged (bus stability) and discard is set; req_addr<=target after the discarded response.
- DATA without rvalid: discard<=1.
- DATA with rvalid in the same cycle: drop the data and go to ADDR with target.
- BUF: invalidate the buffer and go to ADDR with target.

REQ-013 At most one read SHALL be outstanding; a new arvalid SHALL NOT be raised before the prior response is accepted.

REQ-014 enable=0 SHALL NOT abort an issued request; the FSM completes it and rests in IDLE.

REQ-015 pc_q arithmetic SHALL be modulo 2^DATA_WIDTH; an increment from all-ones-minus-3 wraps to 0.

Reset
REQ-016 When nreset=0, asynchronously and regardless of bus state:
- FSM=IDLE, pc_q=RESET_PC, discard=0, buffer empty.
- arvalid=0, rready=0.
- o_valid=0, o_instr=32'h00000013, o_pc=0.

REQ-017 After nreset deasserts, the first arvalid SHALL occur no earlier than the cycle after enable is seen high in IDLE.

REQ-018 Any response to a pre-reset request SHALL be the memory model's responsibility; the block makes no claim on it.

Verification
REQ-019 Sequential fetch: RESET_PC=0x100, zero-wait memory -> araddr 0x100, 0x104, 0x108; o_pc/o_instr match with o_valid=1, one instruction per handshake.

REQ-020 Stall while the response is pending: i_stall=1 as rvalid arrives with 0x00A00093 -> state BUF, outputs hold the previous instruction; stall released -> next cycle o_instr=0x00A00093, o_valid=1.

REQ-021 Redirect in DATA: i_pc_src=1, target 0x203 while waiting on 0x104 -> that response is dropped, next araddr=0x200, o_valid=0 until 0x200 data arrives.

REQ-022 Redirect in ADDR with arready low for 3 cycles -> araddr stays 0x108 until accepted, its data is discarded, then araddr=target.

REQ-023 Reset mid-transaction: nreset low during DATA -> arvalid/rready/o_valid go 0 immediately; after release, fetch restarts at RESET_PC.

REQ-024 Wrap: pc_q=0xFFFF_FFFF_FFFF_FFFC -> next araddr=0x0.
